// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I width codes, FSM states
// and the fault classification used on the latched request.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_FUNCT3   = 2'd1,
    FLT_MISALIGN = 2'd2,
    FLT_RANGE    = 2'd3
  } fault_e;

  function automatic fault_e fault_code(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic       misalign,
                                        input logic       out_of_range);
    if (we ? (funct3 >= 3'd3) : (funct3 == 3'd3 || funct3 >= 3'd6)) return FLT_FUNCT3;
    if (misalign) return FLT_MISALIGN;
    if (out_of_range) return FLT_RANGE;
    return FLT_NONE;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the datapath (master) and the data-memory responder (slave).
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, replicated store data,
// shifted and sign/zero-extended load data, and the alignment check.
module mem_lane_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [4:0]  w_shift;
  logic [31:0] w_lane;

  assign w_shift = {i_addr_lo, 3'b000};
  assign w_lane  = i_rword >> w_shift;

  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = 32'd0;
    o_rdata    = 32'd0;
    o_misalign = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = (i_funct3 == F3_B) ? {{24{w_lane[7]}}, w_lane[7:0]} : {24'd0, w_lane[7:0]};
      end
      F3_H, F3_HU: begin
        o_misalign = i_addr_lo[0];
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = (i_funct3 == F3_H) ? {{16{w_lane[15]}}, w_lane[15:0]}
                                        : {16'd0, w_lane[15:0]};
      end
      F3_W: begin
        o_misalign = |i_addr_lo;
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_rdata    = w_lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_CYCLES wait states, access
// committed on entry to RESP and the response held until the datapath takes it.
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               w_in_idle;
  logic               w_accept;
  logic               w_enter_resp;
  logic               w_we;
  logic [2:0]         w_funct3;
  logic [31:0]        w_addr;
  logic [31:0]        w_wdata;
  logic [IDX_W-1:0]   w_idx;
  logic               w_oor;
  logic               w_misalign;
  logic               w_fault;
  logic               w_mem_we;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata_ln;
  logic [31:0]        w_ld_data;

  assign w_in_idle = (r_state == IDLE);
  assign w_accept  = w_in_idle && bus.req_valid;

  // With no wait states the commit happens on the accept edge, so use the live request.
  assign w_enter_resp = ((r_state == WAIT) && (r_cnt == '0)) || ((WAIT_CYCLES == 0) && w_accept);
  assign w_we         = w_in_idle ? bus.req_we     : r_we;
  assign w_funct3     = w_in_idle ? bus.req_funct3 : r_funct3;
  assign w_addr       = w_in_idle ? bus.req_addr   : r_addr;
  assign w_wdata      = w_in_idle ? bus.req_wdata  : r_wdata;

  assign w_idx    = w_addr[IDX_W+1:2];
  assign w_oor    = ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_fault  = (fault_code(w_we, w_funct3, w_misalign, w_oor) != FLT_NONE);
  assign w_mem_we = w_enter_resp && w_we && !w_fault;

  mem_lane_align u_align (
    .i_funct3   (w_funct3),
    .i_addr_lo  (w_addr[1:0]),
    .i_wdata    (w_wdata),
    .i_rword    (r_mem[w_idx]),
    .o_be       (w_be),
    .o_wdata    (w_wdata_ln),
    .o_rdata    (w_ld_data),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            if (WAIT_CYCLES == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_state <= RESP;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        RESP: begin
          if (bus.resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_enter_resp) begin
        r_rdata <= (w_we || w_fault) ? 32'd0 : w_ld_data;
        r_err   <= w_fault;
      end
    end
  end

  // Storage is deliberately left out of reset so committed stores survive it.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_ln[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = w_in_idle && !reset;
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign bus.busy       = !w_in_idle;

endmodule
